// File: rtl/event_dispatcher_pkg.sv
// Shared types and constants for the event dispatcher: FSM states, priority/vector width,
// and the handler-table address helper.
package event_dispatch_pkg;

   localparam int unsigned VecW = 16;
   localparam logic [VecW-1:0] IdlePriorityDefault = 16'hFFFF;

   typedef enum logic [2:0] {
      StIdle,
      StAck,
      StOffer,
      StRun,
      StHoldoff
   } disp_state_e;

   // Table address wraps modulo 2^VecW.
   function automatic logic [VecW-1:0] calc_vector(input logic [VecW-1:0] base,
                                                   input logic [VecW-1:0] idx,
                                                   input int unsigned     stride);
      logic [31:0] full;
      full = 32'(base) + 32'(idx) * 32'(stride);
      return full[VecW-1:0];
   endfunction

endpackage

// File: rtl/event_dispatcher_if.sv
// Bundle of event_controller / core handshake signals seen by the dispatcher.
interface event_dispatcher_if;
   import event_dispatch_pkg::*;

   logic [VecW-1:0] priority_in;
   logic            ack_load;
   logic [VecW-1:0] ack_data;
   logic            dispatch_enable;
   logic            handler_valid;
   logic [VecW-1:0] handler_vector;
   logic [VecW-1:0] handler_priority;
   logic            handler_accept;
   logic            handler_done;
   logic            busy;
   logic [VecW-1:0] dispatch_count;
   logic            overrun;
   logic            bad_priority;
   logic            status_clear;

   modport master (
      input  priority_in, dispatch_enable, handler_accept, handler_done, status_clear,
      output ack_load, ack_data, handler_valid, handler_vector, handler_priority, busy,
             dispatch_count, overrun, bad_priority
   );

   modport slave (
      output priority_in, dispatch_enable, handler_accept, handler_done, status_clear,
      input  ack_load, ack_data, handler_valid, handler_vector, handler_priority, busy,
             dispatch_count, overrun, bad_priority
   );

endinterface

// File: rtl/event_dispatcher_watchdog.sv
// Saturating handler run-time counter; limit_o pulses on the cycle the count reaches MaxCycles.
module handler_watchdog #(
   parameter logic [15:0] MaxCycles = 16'd5000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic limit_o
);

   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      limit_o = 1'b0;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != MaxCycles)) begin
         count_d = count_q + 16'd1;
         limit_o = (count_d == MaxCycles);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/event_dispatcher.sv
// Atomic snapshot-and-ack of the pending event priority, then a single non-overlapping
// handler offer to the core with a run-time watchdog.
module event_dispatcher
   import event_dispatch_pkg::*;
#(
   parameter int unsigned     NUM_EVENTS         = 64,
   parameter logic [VecW-1:0] IDLE_PRIORITY      = IdlePriorityDefault,
   parameter logic [VecW-1:0] VECTOR_BASE        = 16'h0000,
   parameter int unsigned     VECTOR_STRIDE      = 2,
   parameter logic [15:0]     MAX_HANDLER_CYCLES = 16'd5000
) (
   input  logic                sysclk,
   input  logic                sysreset_n,
   event_dispatcher_if.master  bus
);

   disp_state_e     state_q, state_d;
   logic [VecW-1:0] snapshot_q, snapshot_d;
   logic [VecW-1:0] vector_q, vector_d;
   logic [VecW-1:0] count_q, count_d;
   logic            overrun_q, overrun_d;
   logic            bad_q, bad_d;
   logic            bad_set;
   logic            limit_hit;
   logic            prio_valid;

   assign prio_valid = (32'(bus.priority_in) < NUM_EVENTS);

   handler_watchdog #(
      .MaxCycles (MAX_HANDLER_CYCLES)
   ) u_watchdog (
      .clk_i    (sysclk),
      .rst_ni   (sysreset_n),
      .clear_i  (state_q != StRun),
      .enable_i (state_q == StRun),
      .limit_o  (limit_hit)
   );

   always_comb begin
      state_d    = state_q;
      snapshot_d = snapshot_q;
      vector_d   = vector_q;
      count_d    = count_q;
      bad_set    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.dispatch_enable) begin
               if (prio_valid) begin
                  snapshot_d = bus.priority_in;
                  vector_d   = calc_vector(VECTOR_BASE, bus.priority_in, VECTOR_STRIDE);
                  state_d    = StAck;
               end else if (bus.priority_in != IDLE_PRIORITY) begin
                  bad_set = 1'b1;
               end
            end
         end
         StAck: begin
            count_d = count_q + 16'd1;
            state_d = StOffer;
         end
         StOffer: begin
            if (bus.handler_accept) state_d = StRun;
         end
         StRun: begin
            if (bus.handler_done) state_d = StHoldoff;
         end
         // One spare cycle covers event_controller's clear-to-priority latency.
         StHoldoff: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      bad_d     = bus.status_clear ? 1'b0 : (bad_q | bad_set);
      overrun_d = bus.status_clear ? 1'b0 : (overrun_q | limit_hit);
   end

   always_ff @(posedge sysclk) begin
      if (!sysreset_n) begin
         state_q    <= StIdle;
         snapshot_q <= '0;
         vector_q   <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
         bad_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         snapshot_q <= snapshot_d;
         vector_q   <= vector_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
         bad_q      <= bad_d;
      end
   end

   assign bus.ack_load         = (state_q == StAck);
   assign bus.ack_data         = (state_q == StAck) ? snapshot_q : '0;
   assign bus.handler_valid    = (state_q == StOffer);
   assign bus.handler_vector   = vector_q;
   assign bus.handler_priority = snapshot_q;
   assign bus.busy             = (state_q != StIdle);
   assign bus.dispatch_count   = count_q;
   assign bus.overrun          = overrun_q;
   assign bus.bad_priority     = bad_q;

endmodule
